button_conditioner: RTL and testbench



---
 rtl/btn_pkg.sv | 12 +
 rtl/debounce_channel.sv | 81 ++++++++
 rtl/button_conditioner.sv | 28 ++
 tb/tb_button_conditioner.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state encodings and defaults for the button conditioner
package btn_pkg;

   localparam logic [1:0] ST_IDLE      = 2'b00;
   localparam logic [1:0] ST_WAIT_HIGH = 2'b01;
   localparam logic [1:0] ST_HIGH      = 2'b10;
   localparam logic [1:0] ST_WAIT_LOW  = 2'b11;

   // 10 ms of stable input at 100 MHz
   localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one-bit synchroniser, debounce counter and press-pulse FSM
module debounce_channel
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic i_btn,
   output logic o_level,
   output logic o_pulse
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1;
   logic          s2;
   logic [1:0]    state;
   logic [CW-1:0] cnt;

   // Counter is cleared on every state change, so it can never pass CNT_LAST.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1      <= 1'b0;
         s2      <= 1'b0;
         state   <= ST_IDLE;
         cnt     <= '0;
         o_level <= 1'b0;
         o_pulse <= 1'b0;
      end else begin
         s1      <= i_btn;
         s2      <= s1;
         o_pulse <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (s2) begin
                  state <= ST_WAIT_HIGH;
                  cnt   <= '0;
               end
            end
            ST_WAIT_HIGH: begin
               if (!s2) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state   <= ST_HIGH;
                  cnt     <= '0;
                  o_level <= 1'b1;
                  o_pulse <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_HIGH: begin
               if (!s2) begin
                  state <= ST_WAIT_LOW;
                  cnt   <= '0;
               end
            end
            ST_WAIT_LOW: begin
               if (s2) begin
                  state <= ST_HIGH;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state   <= ST_IDLE;
                  cnt     <= '0;
                  o_level <= 1'b0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - independent debounce channels for the operand-entry push-buttons
module button_conditioner
   import btn_pkg::*;
#(
   parameter int NB_BTN          = 3,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NB_BTN-1:0] i_btn,
   output logic [NB_BTN-1:0] o_level,
   output logic [NB_BTN-1:0] o_pulse
);

   // bit0 -> b_dato1, bit1 -> b_dato2, bit2 -> b_code
   for (genvar g = 0; g < NB_BTN; g++) begin : g_chan
      debounce_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_chan (
         .clk    (clk),
         .reset  (reset),
         .i_btn  (i_btn[g]),
         .o_level(o_level[g]),
         .o_pulse(o_pulse[g])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner against a run-length model
module tb_button_conditioner;

   localparam int NB = 3;
   localparam int D  = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [NB-1:0] i_btn = '1;
   logic [NB-1:0] o_level;
   logic [NB-1:0] o_pulse;

   int total = 0;
   int bad   = 0;
   int cycle = 0;

   logic [2*NB-1:0] exp_q[$];

   // Reference: after a two-sample delay, a level is accepted once the delayed
   // input has disagreed with the current level on D+1 consecutive clock edges.
   logic [NB-1:0] m_s1 = '0;
   logic [NB-1:0] m_s2 = '0;
   logic [NB-1:0] m_level = '0;
   logic [NB-1:0] m_pulse = '0;
   int            run[NB];

   button_conditioner #(.NB_BTN(NB), .DEBOUNCE_CYCLES(D)) dut (
      .clk    (clk),
      .reset  (reset),
      .i_btn  (i_btn),
      .o_level(o_level),
      .o_pulse(o_pulse)
   );

   always #10 clk = ~clk;

   task automatic step(input logic [NB-1:0] b, input logic r);
      logic [NB-1:0] seen;
      @(negedge clk);
      reset = r;
      i_btn = b;
      if (r) begin
         m_s1 = '0;
         m_s2 = '0;
         m_level = '0;
         m_pulse = '0;
         for (int c = 0; c < NB; c++) run[c] = 0;
         #1;
         total++;
         if (o_level !== '0 || o_pulse !== '0) begin
            bad++;
            $display("FAIL async_reset cycle=%0d level=%b pulse=%b expected 000/000", cycle, o_level, o_pulse);
         end
      end else begin
         seen = m_s2;
         m_s2 = m_s1;
         m_s1 = b;
         m_pulse = '0;
         for (int c = 0; c < NB; c++) begin
            if (seen[c] != m_level[c]) begin
               run[c]++;
               if (run[c] == D + 1) begin
                  m_level[c] = ~m_level[c];
                  m_pulse[c] = m_level[c];
                  run[c] = 0;
               end
            end else begin
               run[c] = 0;
            end
         end
      end
      exp_q.push_back({m_level, m_pulse});
   endtask

   task automatic hold(input logic [NB-1:0] b, input int n);
      for (int k = 0; k < n; k++) step(b, 1'b0);
   endtask

   initial begin : monitor
      logic [2*NB-1:0] e;
      forever begin
         @(posedge clk);
         #1;
         cycle++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if ({o_level, o_pulse} !== e) begin
               bad++;
               $display("FAIL out_cmp cycle=%0d level=%b pulse=%b expected level=%b pulse=%b",
                        cycle, o_level, o_pulse, e[2*NB-1:NB], e[NB-1:0]);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      logic [NB-1:0] cur;
      int            hl[NB];
      for (int c = 0; c < NB; c++) run[c] = 0;

      // buttons held through reset, then released reset
      for (int k = 0; k < 3; k++) step(3'b111, 1'b1);
      hold(3'b111, 10);
      hold(3'b000, 10);

      // clean press on channel 0
      hold(3'b001, 20);
      hold(3'b000, 10);

      // bouncy channel 1
      step(3'b010, 1'b0);
      step(3'b000, 1'b0);
      step(3'b010, 1'b0);
      step(3'b000, 1'b0);
      hold(3'b010, 12);
      hold(3'b000, 10);

      // short glitch on channel 2
      hold(3'b100, 3);
      hold(3'b000, 10);

      // simultaneous press
      hold(3'b111, 10);
      hold(3'b000, 10);

      // reset during WAIT_HIGH with the button then dropped
      hold(3'b001, 5);
      step(3'b000, 1'b1);
      hold(3'b000, 12);

      // reset while all levels are high
      hold(3'b111, 10);
      step(3'b000, 1'b1);
      hold(3'b000, 10);

      // randomised bouncing with occasional resets
      cur = '0;
      for (int c = 0; c < NB; c++) hl[c] = 0;
      for (int i = 0; i < 500; i++) begin
         for (int c = 0; c < NB; c++) begin
            if (hl[c] == 0) begin
               cur[c] = 1'($urandom_range(0, 1));
               hl[c]  = int'($urandom_range(1, 9));
            end
            hl[c]--;
         end
         step(cur, ($urandom_range(0, 99) == 0));
      end
      hold(3'b000, 10);

      repeat (3) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain pending=%0d expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
